// File: rtl/ps2_host_tx_if.sv
// Host command port plus the raw PS/2 pins and their open-drain enables.
// The transmitter connects through the slave modport; the surrounding logic uses master.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       rx_inhibit;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;

    modport master (
        output tx_data, tx_start, ps2_clk_in, ps2_data_in,
        input  tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe
    );

    modport slave (
        input  tx_data, tx_start, ps2_clk_in, ps2_data_in,
        output tx_ready, tx_done, tx_err, rx_inhibit, ps2_clk_oe, ps2_data_oe
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, 10 device-clocked
// bits (8 data LSB first, odd parity, stop), then ACK sample and wait for bus idle.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int RTS_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input logic          clk,
    input logic          rst,
    ps2_host_tx_if.slave bus
);
    localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] RTS_LAST = 20'(RTS_CYCLES - 1);
    localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  sh_q, sh_d;
    logic        ack_bad_q, ack_bad_d;
    logic        clk_oe_q, clk_oe_d;
    logic        data_oe_q, data_oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic clk_meta, clk_sync, clk_prev, data_meta, data_sync;
    logic fe;

    // Idle lines are high, so the synchronizer resets to 1 and cannot fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {clk_meta, clk_sync, clk_prev, data_meta, data_sync} <= '1;
        end else begin
            clk_meta  <= bus.ps2_clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= bus.ps2_data_in;
            data_sync <= data_meta;
        end
    end

    assign fe = clk_prev & ~clk_sync;

    // NOTE: non-blocking assignments so every flop samples values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            ack_bad_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            ack_bad_q <= ack_bad_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // NOTE: every *_d signal gets a default before the case, so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        ack_bad_d = ack_bad_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (bus.tx_start) begin
                    sh_d    = {~^bus.tx_data, bus.tx_data};
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_RTS;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = S_SEND;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            S_SEND: begin
                cnt_d = cnt_q + 20'd1;
                if (fe) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    sh_d      = {1'b0, sh_q[8:1]};
                    if (bit_cnt_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else begin
                        data_oe_d = ~sh_q[0];
                    end
                end else if (cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + 20'd1;
                if (fe) begin
                    ack_bad_d = data_sync;
                    state_d   = S_WAIT_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync && data_sync) begin
                    done_d  = ~ack_bad_q;
                    err_d   = ack_bad_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
    end

    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_err      = err_q;
    assign bus.tx_ready    = (state_q == S_IDLE);
    assign bus.rx_inhibit  = (state_q != S_IDLE);
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model drives the wires, and a timeline model of
// expected pin and handshake values is compared against the DUT on every cycle.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int RTS = 4;
    localparam int TO  = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_in  = dev_clk & ~bus.ps2_clk_oe;
    assign bus.ps2_data_in = dev_data & ~bus.ps2_data_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {F_IDLE, F_CLK, F_DATA, F_DONE, F_ERR} field_e;
    typedef struct {
        int     due;
        field_e f;
        bit     v;
    } ev_t;

    ev_t  evq[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    bit   chk_en = 1'b0;
    bit   m_idle = 1'b1, m_clk = 1'b0, m_data = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [7:0] m_byte = 8'h00;
    int   m_send_cyc = 0;
    int   run = 0, last_run = 0, fall_cyc = 0, err_cyc = 0, done_cnt = 0, err_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic void sched(input int due, input field_e f, input bit v);
        ev_t e;
        e.due = due;
        e.f   = f;
        e.v   = v;
        evq.push_back(e);
    endfunction

    // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // A start driven in cycle n is taken only if the model is idle then.
    function automatic void model_start(input logic [7:0] b);
        if (m_idle) begin
            m_byte     = b;
            m_send_cyc = cyc + 1 + INH + RTS;
            sched(cyc + 1, F_IDLE, 1'b0);
            sched(cyc + 1, F_CLK, 1'b1);
            sched(cyc + 1 + INH, F_DATA, 1'b1);
            sched(m_send_cyc, F_CLK, 1'b0);
        end
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle compare against the model, plus pulse and width monitors.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            begin
                int i;
                i = 0;
                while (i < evq.size()) begin
                    if (evq[i].due <= cyc) begin
                        case (evq[i].f)
                            F_IDLE:  m_idle = evq[i].v;
                            F_CLK:   m_clk  = evq[i].v;
                            F_DATA:  m_data = evq[i].v;
                            F_DONE:  m_done = evq[i].v;
                            default: m_err  = evq[i].v;
                        endcase
                        evq.delete(i);
                    end else begin
                        i++;
                    end
                end
            end
            if (chk_en) begin
                check("tx_ready", 32'(bus.tx_ready), 32'(m_idle));
                check("rx_inhibit", 32'(bus.rx_inhibit), 32'(!m_idle));
                check("ps2_clk_oe", 32'(bus.ps2_clk_oe), 32'(m_clk));
                check("ps2_data_oe", 32'(bus.ps2_data_oe), 32'(m_data));
                check("tx_done", 32'(bus.tx_done), 32'(m_done));
                check("tx_err", 32'(bus.tx_err), 32'(m_err));
            end
            if (bus.ps2_clk_oe === 1'b1) begin
                run++;
            end else begin
                if (run != 0) begin
                    last_run = run;
                    fall_cyc = cyc;
                end
                run = 0;
            end
            if (bus.tx_done === 1'b1) done_cnt++;
            if (bus.tx_err === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
        end
    end

    // Device: waits for request-to-send, clocks n_falls bits, then (if all 10) the ACK clock.
    task automatic dev_frame(input int h, input bit ack, input int n_falls, input int busy_k,
                             output logic [10:0] got, output int fin);
        logic [10:0] exp;
        int w;
        exp = frame_of(m_byte);
        got = '0;
        w = 0;
        while (!(bus.ps2_clk_in === 1'b1 && bus.ps2_data_in === 1'b0) && w < 200) begin
            tick();
            w++;
        end
        check("rts_seen", 32'(w < 200), 32'd1);
        repeat (4) tick();
        got[0] = bus.ps2_data_in;
        for (int k = 0; k < n_falls; k++) begin
            dev_clk = 1'b0;
            sched(cyc + 3, F_DATA, ~exp[k+1]);
            if (k == busy_k) begin
                bus.tx_data  = 8'h55;
                bus.tx_start = 1'b1;
                model_start(8'h55);
            end
            tick();
            bus.tx_start = 1'b0;
            repeat (h - 1) tick();
            got[k+1] = bus.ps2_data_in;
            dev_clk = 1'b1;
            repeat (h) tick();
        end
        fin = cyc;
        if (n_falls == 10) begin
            if (ack) dev_data = 1'b0;
            repeat (h) tick();
            dev_clk = 1'b0;
            repeat (h) tick();
            dev_clk = 1'b1;
            if (!ack) begin
                fin = cyc + 3;
                sched(fin, F_IDLE, 1'b1);
                sched(fin, F_ERR, 1'b1);
                sched(fin + 1, F_ERR, 1'b0);
            end
            repeat (h) tick();
            if (ack) begin
                dev_data = 1'b1;
                fin = cyc + 3;
                sched(fin, F_IDLE, 1'b1);
                sched(fin, F_DONE, 1'b1);
                sched(fin + 1, F_DONE, 1'b0);
            end
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_start = 1'b1;
        model_start(b);
        tick();
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic settle(input int fin);
        while (cyc < fin + 2) tick();
    endtask

    // Full transfer with ACK; returns the frame the device sampled.
    task automatic xfer(input logic [7:0] b, input int h, input bit ack, output logic [10:0] got);
        int fin;
        start_tx(b);
        dev_frame(h, ack, 10, -1, got, fin);
        settle(fin);
        check("frame", 32'(got), 32'(frame_of(b)));
    endtask

    initial begin
        logic [10:0] got;
        logic [7:0]  corner_b[3];
        logic        corner_p[3];
        int          fin, d0, e0, w;

        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        tick();
        chk_en = 1'b1;
        tick();
        check("reset_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        check("reset_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_inhibit", 32'(bus.rx_inhibit), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // 0xED with ACK
        d0 = done_cnt; e0 = err_cnt;
        xfer(8'hED, 10, 1'b1, got);
        check("ed_frame_literal", 32'(got), 32'h7DA);
        check("ed_clk_oe_width", 32'(last_run), 32'd24);
        check("ed_done_count", 32'(done_cnt - d0), 32'd1);
        check("ed_err_count", 32'(err_cnt - e0), 32'd0);

        // Parity corners
        corner_b[0] = 8'h00; corner_p[0] = 1'b1;
        corner_b[1] = 8'hFF; corner_p[1] = 1'b1;
        corner_b[2] = 8'h01; corner_p[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d0 = done_cnt;
            xfer(corner_b[i], 7, 1'b1, got);
            check("corner_parity", 32'(got[9]), 32'(corner_p[i]));
            check("corner_done", 32'(done_cnt - d0), 32'd1);
        end

        // NACK
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h3A);
        dev_frame(8, 1'b0, 10, -1, got, fin);
        settle(fin);
        check("nack_err_count", 32'(err_cnt - e0), 32'd1);
        check("nack_done_count", 32'(done_cnt - d0), 32'd0);
        check("nack_lines", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);

        // Timeout: the device never clocks
        e0 = err_cnt;
        start_tx(8'hC4);
        sched(m_send_cyc + TO, F_ERR, 1'b1);
        sched(m_send_cyc + TO, F_IDLE, 1'b1);
        sched(m_send_cyc + TO, F_DATA, 1'b0);
        sched(m_send_cyc + TO + 1, F_ERR, 1'b0);
        w = 0;
        while (err_cnt == e0 && w < 2500) begin
            tick();
            w++;
        end
        check("timeout_seen", 32'(w < 2500), 32'd1);
        check("timeout_len", 32'(err_cyc - fall_cyc), 32'd2000);
        check("timeout_ready", 32'(bus.tx_ready), 32'd1);
        check("timeout_lines", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        repeat (3) tick();

        // Busy start during SEND is ignored; restart in the tx_done cycle
        start_tx(8'hA3);
        dev_frame(7, 1'b1, 10, 2, got, fin);
        check("busy_frame", 32'(got), 32'(frame_of(8'hA3)));
        while (cyc < fin) tick();
        check("restart_done_cycle", 32'(bus.tx_done), 32'd1);
        start_tx(8'h3C);
        check("restart_inhibit", 32'(bus.ps2_clk_oe), 32'd1);
        dev_frame(9, 1'b1, 10, -1, got, fin);
        settle(fin);
        check("restart_frame", 32'(got), 32'(frame_of(8'h3C)));

        // Reset after the 4th falling edge
        start_tx(8'h9A);
        dev_frame(8, 1'b1, 4, -1, got, fin);
        rst = 1'b1;
        evq.delete();
        sched(cyc + 1, F_IDLE, 1'b1);
        sched(cyc + 1, F_CLK, 1'b0);
        sched(cyc + 1, F_DATA, 1'b0);
        sched(cyc + 1, F_DONE, 1'b0);
        sched(cyc + 1, F_ERR, 1'b0);
        tick();
        rst = 1'b0;
        check("rst_mid_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_mid_lines", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        check("rst_mid_pulses", 32'({bus.tx_done, bus.tx_err}), 32'd0);
        tick();
        d0 = done_cnt;
        xfer(8'hFF, 8, 1'b1, got);
        check("rst_after_done", 32'(done_cnt - d0), 32'd1);

        // Randomized transfers
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            int h;
            bit ack;
            b   = 8'($urandom);
            h   = $urandom_range(6, 12);
            ack = ($urandom_range(0, 3) != 0);
            start_tx(b);
            dev_frame(h, ack, 10, -1, got, fin);
            settle(fin);
            check("rand_frame", 32'(got), 32'(frame_of(b)));
        end

        repeat (4) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
